// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default code geometry, the parity-check matrix
// used by the column-sum, check-node and syndrome stages, and the syndrome FSM states.
package ldpc_pkg;

    localparam int LDPC_N     = 8;
    localparam int LDPC_M     = 4;
    localparam int LDPC_SUM_W = 8;

    // Row r occupies bits [r*N +: N]; bit c of a row is column c.
    localparam logic [LDPC_N*LDPC_M-1:0] LDPC_H_MATRIX = 32'h8E4D2B17;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        REPORT
    } syn_state_e;

endpackage

// File: rtl/ldpc_row_parity.sv
// Evaluates one parity check: a row fails when the hard-decision word hits an
// odd number of the columns that row connects.
module ldpc_row_parity
    import ldpc_pkg::*;
#(
    parameter int N = LDPC_N
) (
    input  logic [N-1:0] codeword_i,
    input  logic [N-1:0] h_row_i,
    output logic         row_fail_o
);

    assign row_fail_o = ^(codeword_i & h_row_i);

endmodule

// File: rtl/ldpc_syndrome_checker.sv
// Syndrome checker: slices N column sums to hard decisions, then checks the M rows of H
// one per cycle. Define LDPC_UNSAT_COUNT_EN to add the unsat_count_o failed-row counter.
module ldpc_syndrome_checker
    import ldpc_pkg::*;
#(
    parameter int              N        = LDPC_N,
    parameter int              M        = LDPC_M,
    parameter int              SUM_W    = LDPC_SUM_W,
    parameter logic [N*M-1:0]  H_MATRIX = LDPC_H_MATRIX
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    sum_valid_i,
    input  logic [SUM_W-1:0]        sum_in_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    parity_ok_o,
    output logic [N-1:0]            codeword_o
`ifdef LDPC_UNSAT_COUNT_EN
    ,
    output logic [$clog2(M+1)-1:0]  unsat_count_o
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

    syn_state_e    state_q, state_d;
    logic [CW-1:0] colCnt_q, colCnt_d;
    logic [RW-1:0] rowCnt_q, rowCnt_d;
    logic [N-1:0]  codeword_q, codeword_d;
    logic          failAcc_q, failAcc_d;
    logic          parityOk_q, parityOk_d;
    logic [N-1:0]  hRow;
    logic          rowFail;

    assign hRow = H_MATRIX[int'(rowCnt_q) * N +: N];

    ldpc_row_parity #(
        .N (N)
    ) u_row_parity (
        .codeword_i (codeword_q),
        .h_row_i    (hRow),
        .row_fail_o (rowFail)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            colCnt_q   <= '0;
            rowCnt_q   <= '0;
            codeword_q <= '0;
            failAcc_q  <= 1'b0;
            parityOk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            colCnt_q   <= colCnt_d;
            rowCnt_q   <= rowCnt_d;
            codeword_q <= codeword_d;
            failAcc_q  <= failAcc_d;
            parityOk_q <= parityOk_d;
        end
    end

    // parity_ok is committed on the last CHECK cycle so it becomes visible with done.
    always_comb begin
        state_d    = state_q;
        colCnt_d   = colCnt_q;
        rowCnt_d   = rowCnt_q;
        codeword_d = codeword_q;
        failAcc_d  = failAcc_q;
        parityOk_d = parityOk_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = LOAD;
                    colCnt_d  = '0;
                    rowCnt_d  = '0;
                    failAcc_d = 1'b0;
                end
            end
            LOAD: begin
                if (sum_valid_i) begin
                    codeword_d[colCnt_q] = ($signed(sum_in_i) < 0);
                    if (colCnt_q == COL_LAST) begin
                        state_d = CHECK;
                    end else begin
                        colCnt_d = colCnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                failAcc_d = failAcc_q | rowFail;
                if (rowCnt_q == ROW_LAST) begin
                    state_d    = REPORT;
                    parityOk_d = ~(failAcc_q | rowFail);
                end else begin
                    rowCnt_d = rowCnt_q + 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q == LOAD) || (state_q == CHECK);
    assign done_o      = (state_q == REPORT);
    assign parity_ok_o = parityOk_q;
    assign codeword_o  = codeword_q;

`ifdef LDPC_UNSAT_COUNT_EN
    localparam int UW = $clog2(M + 1);

    logic [UW-1:0] unsat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            unsat_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            unsat_q <= '0;
        end else if (state_q == CHECK) begin
            unsat_q <= unsat_q + UW'(rowFail);
        end
    end

    assign unsat_count_o = unsat_q;
`endif

endmodule
